image_capture_axi_lite_master: RTL
==================================

// Module: image_capture_axi_lite_master
// PURPOSE
// - AXI4-Lite initiator that drives the capture-manager slave register interface from a simple command/response port.
// - Turns one command into one AXI write (AW+W+B) or read (AR+R) and returns the response.
// - Sits between the capture control logic (sequencer or test harness) and the image_capture_manager s00_axi port.
// PARAMETERS
// - C_M00_AXI_DATA_WIDTH  32   data width; wstrb width = DATA_WIDTH/8
// - C_M00_AXI_ADDR_WIDTH  4    address width, byte address
// - TIMEOUT_CYCLES        256  watchdog limit per transaction, cycles (used only with the macro)
// PORTS
// - m00_axi_aclk                  in   1   clock
// - m00_axi_areset                in   1   reset, synchronous, active-high
// - cmd_valid / cmd_ready         in/out 1 command handshake
// - cmd_write                     in   1   1=write, 0=read
// - cmd_addr                      in   ADDR target register byte address
// - cmd_wdata                     in   DATA write data (ignored for reads)
// - rsp_valid / rsp_ready         out/in 1 response handshake
// - rsp_rdata                     out  DATA read data (0 for writes)
// - rsp_resp                      out  2   BRESP/RRESP from slave, or 2'b11 on timeout
// - busy                          out  1   transaction in flight (state != IDLE)
// - m00_axi_awaddr/awprot         out  ADDR/3  write address, prot fixed 3'b000
// - m00_axi_awvalid/awready       out/in 1 AW handshake
// - m00_axi_wdata/wstrb           out  DATA/DATA/8  write data, strobe all ones
// - m00_axi_wvalid/wready         out/in 1 W handshake
// - m00_axi_bresp/bvalid/bready   in/in/out 2/1/1  write response channel
// - m00_axi_araddr/arprot         out  ADDR/3  read address, prot fixed 3'b000
// - m00_axi_arvalid/arready       out/in 1 AR handshake
// - m00_axi_rdata/rresp           in   DATA/2  read data channel
// - m00_axi_rvalid/rready         in/out 1 R handshake
// BEHAVIOUR
// - Reset: all outputs 0 (awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_rdata, rsp_resp, busy, addr/data); state=IDLE; cmd_ready forced 0 while reset is high.
// - FSM: IDLE -> WR_AW_W | RD_AR on cmd_valid&cmd_ready; WR_AW_W -> WR_B; RD_AR -> RD_R; WR_B/RD_R -> RESP; RESP -> IDLE on rsp_ready.
// - IDLE: cmd_ready=1; the command is registered on the handshake; addr/data outputs change only here.
// - WR_AW_W: awvalid and wvalid rise together the cycle after acceptance; each drops independently on its own ready; either order and same-cycle handshakes are legal; leave the state when both are done.
// - WR_B: bready=1; on bvalid capture bresp and set rsp_rdata=0.
// - RD_AR: arvalid=1 until arready. RD_R: rready=1; on rvalid capture rdata and rresp.
// - RESP: rsp_valid=1 and held, with data stable, until rsp_ready; cmd_ready=0.
// - Latency with an always-ready slave: cmd handshake T0 -> AW/W or AR handshake T1 -> B or R handshake T2 -> rsp_valid T3.
// - A valid is never dropped before its ready (AXI rule), except when the timeout fires.
// - Exactly one outstanding transaction; no pipelining; no back-to-back without passing through IDLE.
// - Slave error responses (2'b10) are passed through unchanged; no retry.
// - Reset mid-transaction: all valids/readies drop the cycle after reset is sampled, and any pending response is discarded.
// CONFIGURATION
// - IMAGE_CAPTURE_MASTER_TIMEOUT_EN defined:
//   - A counter clears on cmd acceptance and runs in WR_AW_W/WR_B/RD_AR/RD_R.
//   - When it reaches TIMEOUT_CYCLES-1: drop all AXI valids/readies, go to RESP with rsp_resp=2'b11 and rsp_rdata=0.
// - Not defined: no counter; the block waits indefinitely for the slave.
// TESTING
// - Write addr 0x0 data 0x1, slave always ready, bresp=0 -> awaddr=0x0, wdata=0x1, wstrb=4'hF; rsp_valid at T3 with rsp_resp=0; slave enable output goes to 1.
// - Read addr 0x4, slave returns rdata=0xA5A5_0001 after 3 wait cycles -> arvalid held 3 cycles; rsp_rdata=0xA5A5_0001, rsp_resp=0.
// - Write with wready 2 cycles before awready -> wvalid drops first, awvalid held; exactly one B wait; one response.
// - Slave bresp=2'b10, rsp_ready low 5 cycles -> rsp_valid and rsp_resp=2'b10 held 5 cycles; cmd_ready=0 throughout.
// - Reset asserted in RD_R -> next cycle arvalid=rready=rsp_valid=0 and busy=0; cmd_ready=1 after reset release.
// - With the macro and TIMEOUT_CYCLES=16, arready tied 0 -> arvalid drops after 16 cycles; rsp_resp=2'b11 and rsp_rdata=0.

Source files
------------

// File: rtl/image_capture_axi_lite_master.sv
// AXI4-Lite initiator: turns one command into one AW+W+B write or AR+R read and returns the response.
// Optional per-transaction watchdog enabled by defining IMAGE_CAPTURE_MASTER_TIMEOUT_EN.
module image_capture_axi_lite_master #(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 4
`ifdef IMAGE_CAPTURE_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                                m00_axi_aclk,
  input  logic                                m00_axi_areset,
  // command / response port
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                busy,
  // AXI4-Lite write channels
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                          m00_axi_awprot,
  output logic                                m00_axi_awvalid,
  input  logic                                m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                                m00_axi_wvalid,
  input  logic                                m00_axi_wready,
  input  logic [1:0]                          m00_axi_bresp,
  input  logic                                m00_axi_bvalid,
  output logic                                m00_axi_bready,
  // AXI4-Lite read channels
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                          m00_axi_arprot,
  output logic                                m00_axi_arvalid,
  input  logic                                m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                          m00_axi_rresp,
  input  logic                                m00_axi_rvalid,
  output logic                                m00_axi_rready
);

  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int AW = C_M00_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RESP
  } state_e;

  state_e        state_q,     state_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic          awvalid_q,   awvalid_d;
  logic          wvalid_q,    wvalid_d;
  logic          arvalid_q,   arvalid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_resp_q,  rsp_resp_d;

`ifdef IMAGE_CAPTURE_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Handshake readies and status are pure decodes of the state, so they fall
  // together with the state register on reset or timeout.
  assign cmd_ready       = (state_q == IDLE) && !m00_axi_areset;
  assign busy            = (state_q != IDLE);
  assign m00_axi_bready  = (state_q == WR_B);
  assign m00_axi_rready  = (state_q == RD_R);
  assign rsp_valid       = (state_q == RESP);
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;

  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_arvalid = arvalid_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef IMAGE_CAPTURE_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
`ifdef IMAGE_CAPTURE_MASTER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end

      // AW and W complete independently; move on once neither is pending.
      WR_AW_W: begin
        awvalid_d = awvalid_q & ~m00_axi_awready;
        wvalid_d  = wvalid_q  & ~m00_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_B;
        end
      end

      WR_B: begin
        if (m00_axi_bvalid) begin
          rsp_resp_d  = m00_axi_bresp;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end
      end

      RD_AR: begin
        if (m00_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_R;
        end
      end

      RD_R: begin
        if (m00_axi_rvalid) begin
          rsp_resp_d  = m00_axi_rresp;
          rsp_rdata_d = m00_axi_rdata;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef IMAGE_CAPTURE_MASTER_TIMEOUT_EN
    // Watchdog overrides whatever the slave did this cycle.
    if (state_q inside {WR_AW_W, WR_B, RD_AR, RD_R}) begin
      if (tmo_cnt_q == TMO_LAST) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        rsp_resp_d  = 2'b11;
        rsp_rdata_d = '0;
        state_d     = RESP;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
`ifdef IMAGE_CAPTURE_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef IMAGE_CAPTURE_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

endmodule
